// File: rtl/laser_dp_if.sv
// Request/response port between the search sequencer and the coverage datapath.
interface laser_dp_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] cand_x;
  logic [3:0] cand_y;
  logic       fix_en;
  logic [3:0] fix_x;
  logic [3:0] fix_y;
  logic       resp_valid;
  logic [5:0] resp_cnt;

  modport master (
    output req_valid, cand_x, cand_y, fix_en, fix_x, fix_y,
    input  req_ready, resp_valid, resp_cnt
  );

  modport slave (
    input  req_valid, cand_x, cand_y, fix_en, fix_x, fix_y,
    output req_ready, resp_valid, resp_cnt
  );
endinterface

// File: rtl/laser_search_ctrl.sv
// LASER two-circle search sequencer: loads the point stream, then sweeps all
// 256 centres for one circle at a time, alternating C1/C2 until the covered
// count stops improving, and reports the result with a one-cycle DONE.
module laser_search_ctrl #(
  parameter int NUM_PTS    = 40,
  parameter int MAX_ROUNDS = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic       pt_we,
  output logic [5:0] pt_addr,
  output logic [3:0] pt_x,
  output logic [3:0] pt_y,
  laser_dp_if.master dp,
  output logic [3:0] C1X,
  output logic [3:0] C1Y,
  output logic [3:0] C2X,
  output logic [3:0] C2Y,
  output logic       DONE
);
  localparam int RW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;

  typedef enum logic [2:0] {S_LOAD, S_REQ, S_WAIT, S_UPD, S_DONE} state_t;

  state_t        r_state;
  logic [5:0]    r_load_cnt;
  logic [RW-1:0] r_round;
  logic [7:0]    r_k;
  logic [7:0]    r_best_pos;   // {y, x}
  logic [5:0]    r_best_cnt;
  logic [5:0]    r_prev_cnt;
  logic [3:0]    r_c1x, r_c1y, r_c2x, r_c2y;
  logic          r_done;

  logic [7:0]    w_c1, w_c2, w_tgt;
  logic          w_odd;
  logic          w_term;

  // Even rounds refine C1 against C2; odd rounds refine C2 against C1.
  assign w_c1   = {r_c1y, r_c1x};
  assign w_c2   = {r_c2y, r_c2x};
  assign w_odd  = r_round[0];
  assign w_tgt  = w_odd ? w_c2 : w_c1;
  assign w_term = ((r_round != '0) && (r_best_cnt <= r_prev_cnt)) ||
                  (r_round == RW'(MAX_ROUNDS - 1));

  assign pt_we   = (r_state == S_LOAD);
  assign pt_addr = r_load_cnt;
  assign pt_x    = X;
  assign pt_y    = Y;

  // Request fields come straight from registers, so they hold while req_valid waits.
  assign dp.req_valid = (r_state == S_REQ);
  assign dp.cand_x    = r_k[3:0];
  assign dp.cand_y    = r_k[7:4];
  assign dp.fix_en    = (r_round != '0);
  assign dp.fix_x     = w_odd ? r_c1x : r_c2x;
  assign dp.fix_y     = w_odd ? r_c1y : r_c2y;

  assign C1X  = r_c1x;
  assign C1Y  = r_c1y;
  assign C2X  = r_c2x;
  assign C2Y  = r_c2y;
  assign DONE = r_done;

  // Sequencer FSM: load, per-candidate request/response, round update, done.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_LOAD;
      r_load_cnt <= '0;
      r_round    <= '0;
      r_k        <= '0;
      r_best_pos <= '0;
      r_best_cnt <= '0;
      r_prev_cnt <= '0;
      r_c1x      <= '0;
      r_c1y      <= '0;
      r_c2x      <= '0;
      r_c2y      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_load_cnt <= r_load_cnt + 6'd1;
          if (r_load_cnt == 6'(NUM_PTS - 1)) begin
            r_state    <= S_REQ;
            r_k        <= '0;
            r_best_cnt <= '0;
            r_best_pos <= w_tgt;
          end
        end
        S_REQ: begin
          if (dp.req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (dp.resp_valid) begin
            // Strict compare: on a tie the earlier (lower k) centre is kept.
            if (dp.resp_cnt > r_best_cnt) begin
              r_best_cnt <= dp.resp_cnt;
              r_best_pos <= r_k;
            end
            if (r_k == 8'hFF) begin
              r_state <= S_UPD;
            end else begin
              r_k     <= r_k + 8'd1;
              r_state <= S_REQ;
            end
          end
        end
        S_UPD: begin
          if (w_odd) {r_c2y, r_c2x} <= r_best_pos;
          else       {r_c1y, r_c1x} <= r_best_pos;
          if (w_term) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_prev_cnt <= r_best_cnt;
            r_round    <= r_round + RW'(1);
            r_k        <= '0;
            r_best_cnt <= '0;
            // Next round's target is the other circle, untouched this cycle.
            r_best_pos <= w_odd ? w_c1 : w_c2;
            r_state    <= S_REQ;
          end
        end
        S_DONE: begin
          r_state    <= S_LOAD;
          r_load_cnt <= '0;
          r_round    <= '0;
          r_prev_cnt <= '0;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_laser_search_ctrl.sv
// Bench for laser_search_ctrl: table of whole-image scenarios run through a
// behavioural coverage-datapath model, plus mid-search reset and stray-response sequences.
module tb_laser_search_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] X, Y;
  logic       pt_we;
  logic [5:0] pt_addr;
  logic [3:0] pt_x, pt_y;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       DONE;

  laser_dp_if dp();

  laser_search_ctrl #(.NUM_PTS(40), .MAX_ROUNDS(8)) dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y),
    .pt_we(pt_we), .pt_addr(pt_addr), .pt_x(pt_x), .pt_y(pt_y),
    .dp(dp),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Point memory as the datapath would see it.
  logic [3:0] mem_x [64];
  logic [3:0] mem_y [64];
  always @(posedge CLK) if (!RST && pt_we) begin
    mem_x[pt_addr] <= pt_x;
    mem_y[pt_addr] <= pt_y;
  end

  // Datapath model controls and observations.
  int          scen;
  bit          stall;
  bit          model_en = 1'b0;
  int          n_req;
  int          viol_seq, viol_fix, viol_ovl, viol_stab;

  // Coverage count per scenario; rnd is derived from requests seen this image.
  function automatic int score(input int sc, input int rnd, input int cx, input int cy);
    int r;
    r = (rnd > 9) ? 9 : rnd;
    case (sc)
      0: return (r == 0) ? ((cx == 5 && cy == 7) ? 10 : 0) : 10;
      1: begin
        if (r == 0)      return (cx == 3  && cy == 3)  ? 25 : 5;
        else if (r == 1) return (cx == 12 && cy == 10) ? 38 : 20;
        else             return (cx == 3  && cy == 3)  ? 38 : 30;
      end
      default: return 4 * r + ((cx == r && cy == r) ? 1 : 0);
    endcase
  endfunction

  initial begin : model
    bit          outst;
    bit          prev_stall;
    int          dly;
    int          rnd;
    logic [5:0]  pend;
    logic [16:0] saved;
    outst = 0; prev_stall = 0; dly = 0; pend = '0; saved = '0;
    forever begin
      @(negedge CLK);
      if (RST || !model_en) begin
        outst      = 0;
        prev_stall = 0;
      end else begin
        if (dp.req_valid && outst) viol_ovl++;
        if (prev_stall && (!dp.req_valid ||
            {dp.cand_y, dp.cand_x, dp.fix_en, dp.fix_y, dp.fix_x} !== saved)) viol_stab++;
        prev_stall    = 0;
        dp.resp_valid = 1'b0;
        dp.req_ready  = 1'b0;
        if (outst) begin
          if (dly == 0) begin
            dp.resp_valid = 1'b1;
            dp.resp_cnt   = pend;
            outst         = 0;
          end else dly--;
        end else if (dp.req_valid) begin
          dp.req_ready = !(stall && ($urandom_range(0, 9) < 3));
          if (dp.req_ready) begin
            rnd = n_req / 256;
            if ({dp.cand_y, dp.cand_x} !== 8'(n_req % 256)) viol_seq++;
            if (dp.fix_en !== (rnd != 0)) viol_fix++;
            pend  = 6'(score(scen, rnd, int'(dp.cand_x), int'(dp.cand_y)));
            n_req++;
            outst = 1;
            dly   = stall ? $urandom_range(0, 5) : 0;
          end else begin
            prev_stall = 1;
            saved = {dp.cand_y, dp.cand_x, dp.fix_en, dp.fix_y, dp.fix_x};
          end
        end
      end
    end
  end

  typedef struct {
    int         sc;
    bit         st;
    logic [7:0] c1;      // {y, x}
    logic [7:0] c2;      // {y, x}
    logic [8:0] fx;      // {fix_en, fix_y, fix_x} during DONE
    int         rounds;
  } vec_t;

  vec_t tbl [5];

  // Runs one image starting at a negedge in the first LOAD cycle; returns at the
  // negedge of the cycle after DONE (first LOAD cycle of the next image).
  task automatic run_image(input int idx, input vec_t v, input bit stray, input int abort_at);
    logic [3:0] px [40];
    logic [3:0] py [40];
    int bad_load, bad_mem;
    bit seen, aborted;
    for (int i = 0; i < 40; i++) begin
      px[i] = 4'((i * 3 + idx) % 16);
      py[i] = 4'((i * 5 + idx * 7 + 1) % 16);
    end
    model_en = 1'b0;
    scen = v.sc; stall = v.st; n_req = 0;
    viol_seq = 0; viol_fix = 0; viol_ovl = 0; viol_stab = 0;
    dp.req_ready = 1'b0; dp.resp_valid = 1'b0; dp.resp_cnt = '0;
    bad_load = 0;
    for (int i = 0; i < 40; i++) begin
      X = px[i]; Y = py[i];
      if (stray) begin
        dp.resp_valid = (i == 0);
        dp.resp_cnt   = 6'd40;
      end
      if (!pt_we || pt_addr !== 6'(i) || DONE || dp.req_valid) bad_load++;
      @(negedge CLK);
    end
    dp.resp_valid = 1'b0;
    chk("load_seq", bad_load, 0);
    bad_mem = 0;
    for (int i = 0; i < 40; i++)
      if (mem_x[i] !== px[i] || mem_y[i] !== py[i]) bad_mem++;
    chk("pt_mem", bad_mem, 0);
    chk("first_req", {dp.req_valid, dp.cand_y, dp.cand_x, dp.fix_en}, {1'b1, 8'h00, 1'b0});
    model_en = 1'b1;
    seen = 0; aborted = 0;
    for (int cyc = 0; cyc < 30000 && !seen && !aborted; cyc++) begin
      @(negedge CLK);
      if (DONE) seen = 1;
      else if (abort_at > 0 && n_req >= abort_at && !dp.req_valid) begin
        model_en = 1'b0;
        RST      = 1'b1;
        aborted  = 1;
      end
    end
    if (aborted) return;
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("c1", {C1Y, C1X}, v.c1);
      chk("c2", {C2Y, C2X}, v.c2);
      chk("fix_at_done", {dp.fix_en, dp.fix_y, dp.fix_x}, v.fx);
      chk("req_count", n_req, v.rounds * 256);
      chk("cand_seq", viol_seq, 0);
      chk("fix_en_seq", viol_fix, 0);
      chk("one_outstanding", viol_ovl, 0);
      chk("req_stable", viol_stab, 0);
      @(negedge CLK);
      chk("done_pulse", {DONE, pt_we, pt_addr, dp.req_valid}, {1'b0, 1'b1, 6'd0, 1'b0});
    end
  endtask

  initial begin : main
    tbl[0] = '{0, 1'b0, 8'h75, 8'h00, 9'h175, 2};
    tbl[1] = '{1, 1'b0, 8'h33, 8'hAC, 9'h1AC, 3};
    tbl[2] = '{2, 1'b0, 8'h66, 8'h77, 9'h166, 8};
    tbl[3] = '{1, 1'b1, 8'h33, 8'hAC, 9'h1AC, 3};
    tbl[4] = '{0, 1'b1, 8'h75, 8'h00, 9'h175, 2};

    RST = 1'b1; X = '0; Y = '0;
    dp.req_ready = 1'b0; dp.resp_valid = 1'b0; dp.resp_cnt = '0;
    repeat (2) @(negedge CLK);
    chk("reset_out", {C1X, C1Y, C2X, C2Y, DONE, dp.req_valid, pt_we, pt_addr},
        {16'h0, 1'b0, 1'b0, 1'b1, 6'd0});
    RST = 1'b0;

    // Back-to-back images, no reset between them.
    for (int i = 0; i < 5; i++) run_image(i, tbl[i], 1'b0, 0);

    // Reset in round 1 WAIT; run_image raises RST at the chosen negedge.
    run_image(5, tbl[0], 1'b0, 266);
    @(negedge CLK);
    dp.req_ready = 1'b0; dp.resp_valid = 1'b0;
    chk("midrst_out", {C1X, C1Y, C2X, C2Y, DONE, dp.req_valid, pt_we, pt_addr},
        {16'h0, 1'b0, 1'b0, 1'b1, 6'd0});
    RST = 1'b0;

    // Stray response during LOAD after reset, then a back-to-back image.
    run_image(6, tbl[0], 1'b1, 0);
    run_image(7, tbl[1], 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
